// File: rtl/pia_keyboard_port.sv
// pia_keyboard_port: PIA keyboard register pair (KBD/KBDCR) fed by an
// upper-casing character FIFO with a sticky overflow flag.
module pia_keyboard_port #(
   parameter int DEPTH = 8
) (
   input  logic                    clk14,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    key_valid,
   input  logic [6:0]              key_ascii,
   input  logic                    cs,
   input  logic                    address,
   input  logic                    we,
   input  logic                    flush,
   output logic [7:0]              dout,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    overflow
);
   localparam int AW = $clog2(DEPTH);
   logic [6:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          ovf_q, ovf_d;
   logic          rd_kbd, rd_cr, pop, push, drop, not_empty;
   logic [6:0]    up_char;
   always_comb begin
      rd_kbd    = cs & enable & ~we & ~address;
      rd_cr     = cs & enable & ~we & address;
      not_empty = level_q != '0;
      pop       = rd_kbd & not_empty;
      // a pop in the same cycle frees the slot a full FIFO needs for the push
      push      = key_valid & ((level_q != (AW+1)'(DEPTH)) | pop);
      drop      = key_valid & ~push;
      up_char   = (key_ascii >= 7'h61 && key_ascii <= 7'h7A) ? key_ascii - 7'h20 : key_ascii;
      wr_ptr_d  = flush ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = flush ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d   = flush ? '0 : level_q + (AW+1)'(push) - (AW+1)'(pop);
      ovf_d     = flush ? 1'b0 : drop ? 1'b1 : rd_cr ? 1'b0 : ovf_q;
      dout      = address ? {not_empty, ovf_q, 6'b0} : not_empty ? {1'b1, mem_q[rd_ptr_q]} : 8'h80;
      level     = level_q;
      overflow  = ovf_q;
   end
   always_ff @(posedge clk14 or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end
   // storage is never reset; only entries between the pointers are meaningful
   always_ff @(posedge clk14) begin
      if (push && !flush) mem_q[wr_ptr_q] <= up_char;
   end
endmodule
